fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline; produces the IF/ID register contents (instruction, PC, PC+4) that the decode-stage controller consumes. Owns the fetch PC, issues in-order requests to instruction memory over a valid/ready request channel with an in-order response channel, and buffers returned instructions in a small queue. Handles decode stalls and execute-stage redirects (taken branch/jump), discarding in-flight responses belonging to the squashed path.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_if.sv | 14 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
//   NOP_INSTR     : canonical bubble instruction (addi x0,x0,0)
//   fetch_entry_t : one fetched instruction and its PC
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus: valid/ready request channel plus an in-order
// response channel with no backpressure.
//   master : fetch side (drives req_valid/req_addr)
//   slave  : memory side (drives req_ready and the response)
interface fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_fifo.sv
// Parameterized synchronous FIFO (DEPTH power of 2, >= 2).
//   clk/reset      : clock, sync active-high reset
//   clear          : synchronous flush, wins over push
//   push/pop/din   : write/read strobes; dout shows the head combinationally
//   count/full/empty : occupancy status
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is legal only when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, issues in-order imem requests under a
// credit limit of QDEPTH (in flight + buffered), queues returned words and
// loads the IF/ID register. Redirects squash queued and in-flight work.
//   clk, reset        : clock, sync active-high reset
//   imem (master)     : instruction-memory request/response bus
//   StallD            : hold IF/ID
//   PCSrcE/PCTargetE  : redirect strobe and target from execute
//   InstrD/PCD/PCPlus4D/InstrValidD : IF/ID register contents
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_if.master       imem,
  input  logic          StallD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          InstrValidD
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pcf, pend_pc;
  logic [CW-1:0] outstanding, drop_cnt, qcount, pcount;
  logic [CW:0]   used;
  fetch_entry_t  q_head, rsp_entry;
  logic          accept, rsp, keep, load, q_push, q_pop;
  logic          q_empty, q_full, p_empty, p_full;
  logic          unused_flags;

  assign used             = {1'b0, outstanding} + {1'b0, qcount};
  assign imem.req_valid   = !reset && !PCSrcE && (used < (CW+1)'(QDEPTH));
  assign imem.req_addr    = pcf;
  assign accept           = imem.req_valid && imem.req_ready;
  assign rsp              = imem.rsp_valid;
  // responses owed to a squashed path, or arriving during a redirect, die here
  assign keep             = rsp && (drop_cnt == '0) && !PCSrcE;
  assign load             = !StallD && !PCSrcE;
  assign rsp_entry.pc     = pend_pc;
  assign rsp_entry.instr  = imem.rsp_data;
  assign q_pop            = load && !q_empty;
  // bypass straight into IF/ID when nothing older is waiting
  assign q_push           = keep && !(load && q_empty);
  assign unused_flags     = ^{pcount, p_full, p_empty, q_full};

  // PCs of requests in flight, popped by every response (kept or dropped)
  fetch_fifo #(.W(32), .DEPTH(QDEPTH)) u_pend (
    .clk, .reset, .clear(1'b0), .push(accept), .pop(rsp), .din(pcf),
    .dout(pend_pc), .count(pcount), .full(p_full), .empty(p_empty)
  );

  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_iq (
    .clk, .reset, .clear(PCSrcE), .push(q_push), .pop(q_pop), .din(rsp_entry),
    .dout(q_head), .count(qcount), .full(q_full), .empty(q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf         <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      InstrValidD <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (PCSrcE) begin
        // no request is accepted during a redirect, so everything still
        // outstanding after this cycle's response belongs to the old path
        pcf         <= PCTargetE;
        drop_cnt    <= outstanding - CW'(rsp);
        InstrD      <= NOP_INSTR;
        InstrValidD <= 1'b0;
      end else begin
        if (accept) pcf <= pcf + 32'd4;
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (load) begin
          if (!q_empty) begin
            InstrD      <= q_head.instr;
            PCD         <= q_head.pc;
            PCPlus4D    <= q_head.pc + 32'd4;
            InstrValidD <= 1'b1;
          end else if (keep) begin
            InstrD      <= rsp_entry.instr;
            PCD         <= rsp_entry.pc;
            PCPlus4D    <= rsp_entry.pc + 32'd4;
            InstrValidD <= 1'b1;
          end else begin
            InstrD      <= NOP_INSTR;
            InstrValidD <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order memory with random latency returns
// addr>>2 for each fetch; a reference model tracks fetch PC, path epoch and
// the set of delivered-but-unconsumed instructions to predict every output.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          QD  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD, PCSrcE;
  logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;
  logic        InstrValidD;

  fetch_if imem();

  fetch_stage #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset), .imem(imem), .StallD(StallD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .InstrValidD(InstrValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t        memq[$];
  fetch_entry_t avail[$];
  int           tests = 0, fails = 0, cyc = 0, epoch = 0;
  int           lat_lo = 1, lat_hi = 1;
  logic [31:0]  m_fpc, m_instr, m_pc, m_pc4;
  logic         m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_InstrD"},   InstrD,             m_instr);
    chk({pfx, "_PCD"},      PCD,                m_pc);
    chk({pfx, "_PCPlus4D"}, PCPlus4D,           m_pc4);
    chk({pfx, "_valid"},    32'(InstrValidD),   32'(m_valid));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem.req_ready = 1'b1; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    repeat (n) @(posedge clk);
    #1;
    memq.delete(); avail.delete();
    m_fpc = RPC; m_instr = NOP_INSTR; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    chk("rst_req_valid", 32'(imem.req_valid), 32'd0);
    check_outputs("rst");
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs and memory response, check the request
  // side mid-cycle, then advance the model and check IF/ID after the edge.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t, input logic rdy);
    logic         exp_rv, acc, rv;
    mreq_t        m;
    fetch_entry_t e;
    StallD = s; PCSrcE = r; PCTargetE = t; imem.req_ready = rdy;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    imem.rsp_valid = rv;
    if (rv) imem.rsp_data = memq[0].addr >> 2;
    else    imem.rsp_data = 32'hDEAD_BEEF;
    #1;
    exp_rv = !r && (memq.size() + avail.size() < QD);
    chk("req_valid", 32'(imem.req_valid), 32'(exp_rv));
    chk("req_addr",  imem.req_addr, m_fpc);
    acc = exp_rv && rdy;
    @(posedge clk);
    #1;
    if (rv) begin
      m = memq.pop_front();
      if (m.epoch == epoch && !r) avail.push_back('{pc: m.addr, instr: m.addr >> 2});
    end
    if (acc) begin
      memq.push_back('{addr: m_fpc, due: cyc + int'($urandom_range(lat_hi, lat_lo)), epoch: epoch});
      m_fpc = m_fpc + 32'd4;
    end
    if (r) begin
      epoch++;
      m_fpc = t;
      avail.delete();
      m_instr = NOP_INSTR; m_valid = 1'b0;
    end else if (!s) begin
      if (avail.size() > 0) begin
        e = avail.pop_front();
        m_instr = e.instr; m_pc = e.pc; m_pc4 = e.pc + 32'd4; m_valid = 1'b1;
      end else begin
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end
    end
    cyc++;
    check_outputs("ifid");
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    @(posedge clk); #1;
    do_reset(3);

    // streaming with single-cycle memory
    lat_lo = 1; lat_hi = 1;
    repeat (20) cycle(1'b0, 1'b0, '0, 1'b1);

    // decode stall for four cycles, then release
    repeat (4)  cycle(1'b1, 1'b0, '0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);

    // redirect with two responses still in flight
    lat_lo = 3; lat_hi = 3;
    repeat (6)  cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    chk("redir_bubble", 32'(InstrValidD), 32'd0);
    repeat (12) cycle(1'b0, 1'b0, '0, 1'b1);

    // redirect, stall and response all in one cycle
    lat_lo = 1; lat_hi = 1;
    repeat (5) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("redir_over_stall", 32'(InstrValidD), 32'd0);
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("wrap_addr", imem.req_addr, 32'h0000_0000);
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);

    // random ready, latency 1..3, sparse stalls and redirects
    lat_lo = 1; lat_hi = 3;
    repeat (400)
      cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 19) == 0),
            32'($urandom) & 32'hFFFF_FFFC, logic'($urandom_range(0, 1)));

    // reset in the middle of traffic
    do_reset(2);
    lat_lo = 1; lat_hi = 1;
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
